// File: rtl/rat_int_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rat_int_ctrl
// Description : RAT CPU interrupt controller. Synchronises and filters the
//               external interrupt line, holds the pending request and the
//               I flag, runs the IDLE/SERVICE/RESTORE handshake with the
//               control unit, and snapshots/restores the C/Z flags.
// Options     : RAT_INT_OVF_EN adds the sticky int_ovf overflow output.
// Revision    : 1.0 - initial release
// ============================================================================
module rat_int_ctrl #(
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int FILTER_CYC  = 1    // 1..15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic intr_in,
    input  logic i_set,
    input  logic i_clr,
    input  logic int_ack,
    input  logic reti,
    input  logic reti_ie,
    input  logic c_in,
    input  logic z_in,
    output logic int_req,
    output logic i_flag,
    output logic c_shad,
    output logic z_shad,
    output logic flg_shad_ld,
    output logic flg_ld_sel,
`ifdef RAT_INT_OVF_EN
    output logic int_ovf,
`endif
    output logic in_service
);

    localparam logic [3:0] c_FILT = 4'(FILTER_CYC);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SERVICE = 2'd1,
        S_RESTORE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic [3:0]               r_filt_cnt;
    logic                     r_pending;
    logic                     r_i_flag;
    logic                     r_c_shad;
    logic                     r_z_shad;
    logic                     w_sync_out;
    logic                     w_edge;
    logic                     w_int_req;
    logic                     w_accept;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    // Edge fires on the cycle the counter steps onto FILTER_CYC; it then
    // saturates, so a single high period produces exactly one event.
    assign w_edge     = w_sync_out && (r_filt_cnt == (c_FILT - 4'd1));
    assign w_int_req  = r_pending && r_i_flag && (r_state == S_IDLE);
    // An acknowledge only counts when a request is actually being presented.
    assign w_accept   = int_ack && w_int_req;

    // Synchroniser chain and glitch-filter counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_filt_cnt <= 4'd0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], intr_in};
            if (!w_sync_out) begin
                r_filt_cnt <= 4'd0;
            end else if (r_filt_cnt != c_FILT) begin
                r_filt_cnt <= r_filt_cnt + 4'd1;
            end
        end
    end

    // Pending latch (a new edge beats a same-cycle accept) and I flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_i_flag  <= 1'b0;
        end else begin
            if (w_edge) begin
                r_pending <= 1'b1;
            end else if (w_accept) begin
                r_pending <= 1'b0;
            end
            if (w_accept) begin
                r_i_flag <= 1'b0;
            end else if (reti && reti_ie) begin
                r_i_flag <= 1'b1;
            end else if (i_clr) begin
                r_i_flag <= 1'b0;
            end else if (i_set) begin
                r_i_flag <= 1'b1;
            end
        end
    end

    // Shadow C/Z capture on interrupt entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_shad <= 1'b0;
            r_z_shad <= 1'b0;
        end else if (w_accept) begin
            r_c_shad <= c_in;
            r_z_shad <= z_in;
        end
    end

`ifdef RAT_INT_OVF_EN
    logic r_int_ovf;

    // Sticky overflow: an edge lands on an already-pending request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_ovf <= 1'b0;
        end else if (w_edge && r_pending && !int_ack) begin
            r_int_ovf <= 1'b1;
        end else if (i_clr) begin
            r_int_ovf <= 1'b0;
        end
    end

    assign int_ovf = r_int_ovf;
`endif

    // Service state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_service  = 1'b0;
        flg_shad_ld = 1'b0;
        flg_ld_sel  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_SERVICE;
                end
            end
            S_SERVICE: begin
                in_service = 1'b1;
                if (reti) begin
                    w_state_nxt = S_RESTORE;
                end
            end
            S_RESTORE: begin
                flg_shad_ld = 1'b1;
                flg_ld_sel  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign int_req = w_int_req;
    assign i_flag  = r_i_flag;
    assign c_shad  = r_c_shad;
    assign z_shad  = r_z_shad;

endmodule
`default_nettype wire
